// File: rtl/cordic_pkg.sv
// Shared definitions for the linear-mode CORDIC multiplier.
// Defaults, fixed-point constant helpers and the FSM state type.
package cordic_pkg;

  localparam int DEF_WORD_LENGTH       = 18;
  localparam int DEF_FRAC_LENGTH       = 11;
  localparam int DEF_NUM_OF_ITERATIONS = 11;
  localparam int DEF_SCALE             = 5;

  function automatic int fx_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic int fx_half(input int frac);
    return fx_one(frac) >> 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/cordic_linear_microrotation.sv
// One linear-mode rotation step: d = sign(z), y += d*x>>>s,
// z -= d*(1.0>>s); y and z hold once z reaches zero.
module cordic_linear_microrotation
  import cordic_pkg::*;
#(
  parameter int ACC_W       = 25,
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int FRAC_LENGTH = DEF_FRAC_LENGTH,
  parameter int SHIFT_W     = 4
) (
  input  logic signed [ACC_W-1:0]       y,
  input  logic signed [WORD_LENGTH-1:0] z,
  input  logic signed [ACC_W-1:0]       x,
  input  logic        [SHIFT_W-1:0]     shift,
  output logic signed [ACC_W-1:0]       y_next,
  output logic signed [WORD_LENGTH-1:0] z_next
);

  localparam logic signed [WORD_LENGTH-1:0] ONE =
    WORD_LENGTH'(fx_one(FRAC_LENGTH));

  logic signed [ACC_W-1:0]       x_sh;
  logic signed [WORD_LENGTH-1:0] step;

  assign x_sh = x >>> shift;
  assign step = ONE >>> shift;

  always_comb begin
    y_next = y;
    z_next = z;
    if (z != '0) begin
      if (z[WORD_LENGTH-1]) begin
        y_next = y - x_sh;
        z_next = z + step;
      end else begin
        y_next = y + x_sh;
        z_next = z - step;
      end
    end
  end

endmodule

// File: rtl/linear_cordic_multiplier.sv
// Iterative linear CORDIC multiplier: Product = X*Z, one
// micro-rotation per cycle, fixed latency, saturating output.
module linear_cordic_multiplier
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH       = DEF_WORD_LENGTH,
  parameter int FRAC_LENGTH       = DEF_FRAC_LENGTH,
  parameter int NUM_OF_ITERATIONS = DEF_NUM_OF_ITERATIONS,
  parameter int SCALE             = DEF_SCALE
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Enable,
  input  logic signed [WORD_LENGTH-1:0] Multiplicand,
  input  logic signed [WORD_LENGTH-1:0] Multiplier,
  output logic signed [WORD_LENGTH-1:0] Product,
  output logic                          Valid,
  output logic                          Busy
);

  localparam int ACC_W  = WORD_LENGTH + SCALE + 2;
  // y carries SCALE guard bits below the product LSB to keep
  // the truncation of x>>>i from accumulating across iterations.
  localparam int GUARD  = SCALE;
  localparam int CNT_W  = $clog2(NUM_OF_ITERATIONS + 2);
  localparam int WIDE_W = ACC_W + SCALE + 1;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NUM_OF_ITERATIONS);
  localparam logic signed [WORD_LENGTH-1:0] ONE =
    WORD_LENGTH'(fx_one(FRAC_LENGTH));
  localparam logic signed [WIDE_W-1:0] P_MAX =
    {{(WIDE_W-WORD_LENGTH+1){1'b0}},
     {(WORD_LENGTH-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] P_MIN =
    {{(WIDE_W-WORD_LENGTH+1){1'b1}},
     {(WORD_LENGTH-1){1'b0}}};
  localparam logic signed [WIDE_W-1:0] BIAS =
    WIDE_W'(fx_half(GUARD));

  state_t                        state;
  logic signed [WORD_LENGTH-1:0] x_q;
  logic signed [WORD_LENGTH-1:0] z_q;
  logic signed [WORD_LENGTH-1:0] z_next;
  logic signed [ACC_W-1:0]       y_q;
  logic signed [ACC_W-1:0]       y_next;
  logic signed [ACC_W-1:0]       x_ext;
  logic        [CNT_W-1:0]       cnt;
  logic                          scaled;
  logic                          big_z;
  logic signed [WIDE_W-1:0]      y_wide;
  logic signed [WIDE_W-1:0]      y_round;
  logic signed [WORD_LENGTH-1:0] prod_sat;

  assign big_z = (Multiplier >= ONE) || (Multiplier <= -ONE);
  assign x_ext = ACC_W'(x_q) <<< GUARD;

  cordic_linear_microrotation #(
    .ACC_W       (ACC_W),
    .WORD_LENGTH (WORD_LENGTH),
    .FRAC_LENGTH (FRAC_LENGTH),
    .SHIFT_W     (CNT_W)
  ) u_rot (
    .y      (y_q),
    .z      (z_q),
    .x      (x_ext),
    .shift  (cnt),
    .y_next (y_next),
    .z_next (z_next)
  );

  // Undo range reduction, drop guard bits with rounding, clamp.
  always_comb begin
    y_wide = WIDE_W'(y_q);
    if (scaled)
      y_wide = y_wide <<< SCALE;
    y_round = (y_wide + BIAS) >>> GUARD;
    if (y_round > P_MAX)
      prod_sat = P_MAX[WORD_LENGTH-1:0];
    else if (y_round < P_MIN)
      prod_sat = P_MIN[WORD_LENGTH-1:0];
    else
      prod_sat = y_round[WORD_LENGTH-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      x_q     <= '0;
      z_q     <= '0;
      y_q     <= '0;
      cnt     <= '0;
      scaled  <= 1'b0;
      Product <= '0;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      Valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Enable) begin
            x_q <= Multiplicand;
            y_q <= '0;
            cnt <= '0;
            if (big_z) begin
              z_q    <= Multiplier >>> SCALE;
              scaled <= 1'b1;
            end else begin
              z_q    <= Multiplier;
              scaled <= 1'b0;
            end
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          y_q <= y_next;
          z_q <= z_next;
          if (cnt == LAST)
            state <= DONE;
          else
            cnt <= cnt + CNT_W'(1);
        end
        DONE: begin
          Product <= prod_sat;
          Valid   <= 1'b1;
          Busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_cordic_multiplier.sv
// Directed and randomized checks of the CORDIC multiplier
// against an exact-arithmetic reference with tolerance.
module tb_linear_cordic_multiplier;

  localparam int WL   = 18;
  localparam int ONE  = 2048;
  localparam int PMAX = 131071;
  localparam int PMIN = -131072;

  logic                 CLK;
  logic                 RST;
  logic                 Enable;
  logic signed [WL-1:0] Multiplicand;
  logic signed [WL-1:0] Multiplier;
  logic signed [WL-1:0] Product;
  logic                 Valid;
  logic                 Busy;

  int checks   = 0;
  int failures = 0;

  linear_cordic_multiplier dut (
    .CLK          (CLK),
    .RST          (RST),
    .Enable       (Enable),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .Valid        (Valid),
    .Busy         (Busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int model(input int x, input int z);
    longint p;
    longint q;
    p = longint'(x) * longint'(z);
    if (p >= 0)
      q = (p + ONE / 2) / ONE;
    else
      q = -((-p + ONE / 2) / ONE);
    if (q > PMAX) q = PMAX;
    if (q < PMIN) q = PMIN;
    return int'(q);
  endfunction

  function automatic int tol_for(input int z);
    return (z >= ONE || z <= -ONE) ? 128 : 4;
  endfunction

  task automatic chk_eq(input string tag, input int got,
                        input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int got,
                         input int exp, input int tol);
    checks++;
    assert (got >= exp - tol && got <= exp + tol) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d tol=%0d",
             tag, got, exp, tol);
    end
  endtask

  // Start one op; optionally inject a second Enable at cycle inj.
  task automatic run(input int x, input int z, input int inj,
                     output int lat, output int busy_n,
                     output int pulses, output int prod);
    @(negedge CLK);
    Enable       = 1'b1;
    Multiplicand = WL'(x);
    Multiplier   = WL'(z);
    @(negedge CLK);
    Enable = 1'b0;
    lat    = -1;
    busy_n = Busy ? 1 : 0;
    pulses = 0;
    prod   = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (inj != 0 && n == inj) begin
        Enable       = 1'b1;
        Multiplicand = WL'(999);
        Multiplier   = WL'(777);
      end else begin
        Enable = 1'b0;
      end
      if (Busy) busy_n++;
      if (Valid) begin
        pulses++;
        if (lat < 0) begin
          lat  = n;
          prod = int'(Product);
        end
      end
    end
  endtask

  initial begin
    int lat, busy_n, pulses, prod, x, z, held;
    RST          = 1'b1;
    Enable       = 1'b0;
    Multiplicand = '0;
    Multiplier   = '0;
    repeat (2) @(negedge CLK);
    chk_eq("rst_product", int'(Product), 0);
    chk_eq("rst_valid", int'(Valid), 0);
    chk_eq("rst_busy", int'(Busy), 0);
    RST = 1'b0;

    run(3072, 1536, 0, lat, busy_n, pulses, prod);
    chk_tol("basic_prod", prod, 2304, 4);
    chk_eq("basic_latency", lat, 13);
    chk_eq("basic_busy_cycles", busy_n, 13);
    chk_eq("basic_pulses", pulses, 1);
    held = int'(Product);
    repeat (3) @(negedge CLK);
    chk_eq("hold_product", int'(Product), prod);
    chk_eq("hold_product_2", held, prod);
    chk_eq("hold_valid", int'(Valid), 0);

    run(4096, 6144, 0, lat, busy_n, pulses, prod);
    chk_tol("scaled_prod", prod, 12288, 128);
    chk_eq("scaled_latency", lat, 13);

    run(-2048, 1024, 0, lat, busy_n, pulses, prod);
    chk_tol("neg_x_prod", prod, -1024, 4);
    run(5000, 0, 0, lat, busy_n, pulses, prod);
    chk_eq("zero_z_prod", prod, 0);

    run(122880, 6144, 0, lat, busy_n, pulses, prod);
    chk_eq("sat_prod", prod, PMAX);

    run(3072, 1536, 3, lat, busy_n, pulses, prod);
    chk_tol("ignore_prod", prod, 2304, 4);
    chk_eq("ignore_latency", lat, 13);
    chk_eq("ignore_pulses", pulses, 1);

    @(negedge CLK);
    Enable       = 1'b1;
    Multiplicand = WL'(3072);
    Multiplier   = WL'(1536);
    @(negedge CLK);
    Enable = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk_eq("midrst_valid", int'(Valid), 0);
    end
    RST = 1'b0;
    @(negedge CLK);
    chk_eq("midrst_product", int'(Product), 0);
    chk_eq("midrst_busy", int'(Busy), 0);
    run(2048, 2048, 0, lat, busy_n, pulses, prod);
    chk_tol("post_rst_prod", prod, 2048, 4);
    chk_eq("post_rst_latency", lat, 13);
    chk_eq("post_rst_pulses", pulses, 1);

    @(negedge CLK);
    RST    = 1'b1;
    Enable = 1'b1;
    @(negedge CLK);
    RST    = 1'b0;
    Enable = 1'b0;
    chk_eq("rst_prio_busy", int'(Busy), 0);
    @(negedge CLK);
    chk_eq("rst_prio_busy_2", int'(Busy), 0);
    chk_eq("rst_prio_valid", int'(Valid), 0);

    for (int i = 0; i < 8; i++) begin
      x = int'($urandom_range(8192, 0)) - 4096;
      z = int'($urandom_range(4094, 0)) - 2047;
      run(x, z, 0, lat, busy_n, pulses, prod);
      chk_tol("rand_prod", prod, model(x, z), tol_for(z));
      chk_eq("rand_latency", lat, 13);
    end

    for (int i = 0; i < 4; i++) begin
      x = int'($urandom_range(4096, 0)) - 2048;
      z = int'($urandom_range(2000, 64)) * 32;
      if ($urandom_range(1, 0) == 1) z = -z;
      run(x, z, 0, lat, busy_n, pulses, prod);
      chk_tol("rand_scaled_prod", prod, model(x, z),
              tol_for(z));
      chk_eq("rand_scaled_pulses", pulses, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
